sat_block_accumulator: RTL and testbench
========================================

# sat_block_accumulator

Parametrised multi-channel saturating block accumulator for the pixel-processing datapath. It accepts signed dot-product results tagged with a channel index and accumulates each channel with immediate two's-complement saturation. When a channel has taken `BLK_LEN` samples (default 64 = one 8x8 block), it emits one result through a valid/ready output register and restarts. It sits after the multiply/sum stage and generalises the fixed 4-channel, 16-bit accumulator to N channels, arbitrary widths, block framing and backpressure.

## Interface
- `NCH`, 4: number of channels, ≥2.
- `IN_W`, 16: signed input sample width, ≤ `ACC_W`.
- `ACC_W`, 16: signed accumulator/result width.
- `BLK_LEN`, 64: samples per channel per block, ≥2.
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous clear of all channel state.
- `in_valid` in 1: sample present.
- `in_ready` out 1: sample accepted when `in_valid & in_ready`.
- `in_ch` in `$clog2(NCH)`: channel index. Values ≥ `NCH` are ignored; the sample is consumed with no effect.
- `in_data` in `IN_W`: signed sample.
- `out_valid` out 1: result held.
- `out_ready` in 1: downstream accept.
- `out_ch` out `$clog2(NCH)`: channel of the result.
- `out_data` out `ACC_W`: signed block sum.
- `out_sat` out 1: saturation occurred at least once in this block.
- `res_bus` out `NCH*ACC_W`: last completed result per channel. Channel k occupies `[k*ACC_W +: ACC_W]`.

## Operation
- Per-channel state: `acc` (`ACC_W`, signed), `cnt` (`$clog2(BLK_LEN)` bits), and a `sat` sticky flag.
- Add rule:
  - Sign-extend `in_data` and `acc` to `ACC_W+1` bits and add.
  - If the top two bits differ, clamp: positive overflow gives 2^(ACC_W-1)-1, negative overflow gives -2^(ACC_W-1), and `sat` is set.
  - Saturation acts on the same add. No wrap value is ever stored.
  - Saturation is not sticky in value: an add that moves back in range proceeds normally.
- Block completion, when an accepted sample has `cnt == BLK_LEN-1`:
  - The clamped sum, channel and `sat | overflow_now` load into the output register. `out_valid` is set.
  - `res_bus` slice for that channel is updated to the same sum.
  - The channel's `acc`, `cnt` and `sat` return to 0.
- Other accepted samples: `acc` is updated and `cnt` increments.
- `in_ready = ~clr & ~(out_valid & ~out_ready)`. The whole input stalls while a result waits. Consequently a completion can never find the output register full.
- Output handshake: the register stays stable while `out_valid & ~out_ready`. When `out_valid & out_ready` occurs with no new completion, `out_valid` falls next cycle. When a handshake and a completion coincide, the register reloads and `out_valid` stays high.
- `clr`:
  - Zeroes `acc`, `cnt` and `sat` of all channels next cycle.
  - Does not touch the output register or `res_bus`.
  - Has priority over a same-cycle sample, which is not accepted (`in_ready` = 0).

## Timing
- Reset values: all `acc`, `cnt`, `sat` = 0; `out_valid` = 0; `out_ch` = 0; `out_data` = 0; `out_sat` = 0; `res_bus` = 0. `in_ready` = 1 once `n_rst` is released.
- Accumulate latency is one cycle: a sample accepted at edge N is visible in `acc` after N.
- Result latency is one cycle: the completing sample accepted at edge N gives `out_valid` = 1 and an updated `res_bus` after N.
- Throughput is one sample per cycle on any channel mix, including back-to-back samples on the same channel.
- `n_rst` asserted mid-block discards all partial sums and any pending output immediately.

## Structure
- `acc_pkg`:
  - `ch_idx_t` width helper.
  - Saturation constants `ACC_MAX` and `ACC_MIN` as functions of `ACC_W`.
  - `sat_add` function returning `{overflow, sum}`.
- The per-channel state is a register array inside a single module.
- One natural sub-module is `sat_adder` (combinational, parametrised `ACC_W`). It is shared by all channels, because only one channel updates per cycle.

## Test plan
- Default params. Ch2 receives 64 × +1 with `out_ready` = 1. Required: one `out_valid` pulse with `out_ch` = 2, `out_data` = 64, `out_sat` = 0, and `res_bus[47:32]` = 64. Other slices stay 0.
- Ch0 receives 0x7000, 0x7000, then 62 × 0. Required: `acc` = 0x7FFF after the second sample; result 0x7FFF with `out_sat` = 1.
- Ch1 receives 3 × 0x8000, then +1, then 60 × 0. Required: `acc` holds 0x8000, then becomes 0x8001; result 0x8001 with `out_sat` = 1.
- Hold `out_ready` = 0 at a completion. Required: `in_ready` drops the next cycle, and `out_data`/`out_ch` are stable for 5 cycles. `out_ready` = 1 completes the handshake, and `in_ready` returns the following cycle.
- Round-robin 4 × 64 samples with ch k value k+1. Required: 4 results of 64, 128, 192 and 256 in completion order ch0..ch3, with correct `res_bus`.
- Drive 10 samples on ch3, then `clr` together with `in_valid`, then 64 × +1. Required: the `clr`-cycle sample is not accepted, and the result is 64. Repeat the test with `n_rst` in place of `clr`; all outputs read 0 during reset.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared helpers for the saturating block accumulator.
//   ch_idx_w(n) : width of a channel index for n channels (minimum 1).
//   acc_max(w)  : largest signed value in w bits, 2^(w-1)-1.
//   acc_min(w)  : smallest signed value in w bits, -2^(w-1).
//   sat_add     : signed add with clamping, returns {overflow, clamped sum}.
// Helpers work on a 64-bit carrier, so accumulator widths must be at most 63 bits.
package acc_pkg;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] acc_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Operands are already sign-extended w-bit values, so the 64-bit sum is exact
    // and an out-of-range result is exactly the w+1-bit "top two bits differ" case.
    function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int unsigned        w);
        logic signed [63:0] s;
        s = a + b;
        if (s > acc_max(w)) begin
            return {1'b1, acc_max(w)};
        end else if (s < acc_min(w)) begin
            return {1'b1, acc_min(w)};
        end
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/sat_adder.sv
// sat_adder: combinational ACC_W-bit signed saturating adder.
//   i_a, i_b : signed ACC_W-bit operands
//   o_sum    : clamped sum (never a wrapped value)
//   o_ovf    : high when the true sum was out of range and was clamped
module sat_adder
    import acc_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic signed [63:0] w_a;
    logic signed [63:0] w_b;
    logic        [64:0] w_res;

    assign w_a   = 64'(signed'(i_a));
    assign w_b   = 64'(signed'(i_b));
    assign w_res = sat_add(w_a, w_b, ACC_W);
    assign o_ovf = w_res[64];
    assign o_sum = ACC_W'(w_res);

endmodule

// File: rtl/sat_block_accumulator.sv
// sat_block_accumulator: multi-channel saturating block accumulator.
// Each channel sums BLK_LEN signed samples with immediate saturation, then emits one
// result through a valid/ready output register and restarts.
//   clk, n_rst   : clock, asynchronous active-low reset
//   i_clr        : synchronous clear of all channel state (output side untouched)
//   i_in_valid   : sample present; o_in_ready: sample accepted when both high
//   i_in_ch      : channel index (indices >= NCH are consumed with no effect)
//   i_in_data    : signed IN_W-bit sample
//   o_out_valid  : result held; i_out_ready: downstream accept
//   o_out_ch     : channel of the result; o_out_data: signed block sum
//   o_out_sat    : saturation occurred at least once in that block
//   o_res_bus    : last completed result per channel, channel k at [k*ACC_W +: ACC_W]
module sat_block_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned IN_W    = 16,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned BLK_LEN = 64
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      i_clr,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [ch_idx_w(NCH)-1:0]  i_in_ch,
    input  logic [IN_W-1:0]           i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [ch_idx_w(NCH)-1:0]  o_out_ch,
    output logic [ACC_W-1:0]          o_out_data,
    output logic                      o_out_sat,
    output logic [NCH*ACC_W-1:0]      o_res_bus
);

    localparam int unsigned CH_W  = ch_idx_w(NCH);
    localparam int unsigned CNT_W = $clog2(BLK_LEN);

    // Per-channel state
    logic [ACC_W-1:0] r_acc [NCH];
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [NCH-1:0]   r_sat;
    logic [ACC_W-1:0] r_res [NCH];

    // Output register
    logic             r_out_valid;
    logic [CH_W-1:0]  r_out_ch;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_sat;

    logic                   w_ch_ok;
    logic                   w_accept;
    logic                   w_upd;
    logic                   w_last;
    logic                   w_ovf;
    logic                   w_sat_now;
    logic [CH_W-1:0]        w_idx;
    logic signed [IN_W-1:0] w_din_s;
    logic [ACC_W-1:0]       w_din;
    logic [ACC_W-1:0]       w_sum;

    // Stalling the whole input while a result waits guarantees a completion never
    // finds the output register occupied.
    assign o_in_ready = ~i_clr & ~(r_out_valid & ~i_out_ready);
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_ch_ok    = 32'(i_in_ch) < NCH;
    assign w_upd      = w_accept & w_ch_ok;
    // Keep the array index in range even for ignored channel numbers.
    assign w_idx      = w_ch_ok ? i_in_ch : '0;

    assign w_din_s    = i_in_data;
    assign w_din      = ACC_W'(w_din_s);

    assign w_last     = (r_cnt[w_idx] == CNT_W'(BLK_LEN - 1));
    assign w_sat_now  = r_sat[w_idx] | w_ovf;

    // Only one channel updates per cycle, so a single adder serves all of them.
    sat_adder #(
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .i_a   (r_acc[w_idx]),
        .i_b   (w_din),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_acc[k] <= '0;
                r_cnt[k] <= '0;
            end
            r_sat <= '0;
        end else if (i_clr) begin
            for (int k = 0; k < NCH; k++) begin
                r_acc[k] <= '0;
                r_cnt[k] <= '0;
            end
            r_sat <= '0;
        end else if (w_upd) begin
            if (w_last) begin
                r_acc[w_idx] <= '0;
                r_cnt[w_idx] <= '0;
                r_sat[w_idx] <= 1'b0;
            end else begin
                r_acc[w_idx] <= w_sum;
                r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
                r_sat[w_idx] <= w_sat_now;
            end
        end
    end

    // A completion reloads the register even while a handshake happens in the same
    // cycle; otherwise an accepted result drops valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_res[k] <= '0;
            end
        end else if (w_upd && w_last) begin
            r_out_valid  <= 1'b1;
            r_out_ch     <= w_idx;
            r_out_data   <= w_sum;
            r_out_sat    <= w_sat_now;
            r_res[w_idx] <= w_sum;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_ch    = r_out_ch;
    assign o_out_data  = r_out_data;
    assign o_out_sat   = r_out_sat;

    always_comb begin
        o_res_bus = '0;
        for (int k = 0; k < NCH; k++) begin
            o_res_bus[k*ACC_W +: ACC_W] = r_res[k];
        end
    end

endmodule

// File: tb/tb_sat_block_accumulator.sv
// Bench for sat_block_accumulator with default parameters. A behavioural model
// pushes expected results to a queue as samples are accepted; a monitor pops and
// compares whenever the DUT hands a result over.
module tb_sat_block_accumulator;

    localparam int NCH   = 4;
    localparam int ACC_W = 16;
    localparam int BLK   = 64;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic                 clk;
    logic                 n_rst;
    logic                 i_clr;
    logic                 i_in_valid;
    logic                 o_in_ready;
    logic [1:0]           i_in_ch;
    logic [15:0]          i_in_data;
    logic                 o_out_valid;
    logic                 i_out_ready;
    logic [1:0]           o_out_ch;
    logic [15:0]          o_out_data;
    logic                 o_out_sat;
    logic [NCH*ACC_W-1:0] o_res_bus;

    sat_block_accumulator dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_clr       (i_clr),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_ch     (i_in_ch),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_ch    (o_out_ch),
        .o_out_data  (o_out_data),
        .o_out_sat   (o_out_sat),
        .o_res_bus   (o_res_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        sat;
    } res_t;

    res_t        q[$];
    longint      m_acc [NCH];
    int          m_cnt [NCH];
    bit          m_sat [NCH];
    logic [15:0] m_res [NCH];
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input bit with_res);
        for (int k = 0; k < NCH; k++) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
            m_sat[k] = 0;
            if (with_res) m_res[k] = '0;
        end
    endtask

    function automatic logic [NCH*ACC_W-1:0] exp_bus();
        logic [NCH*ACC_W-1:0] b;
        for (int k = 0; k < NCH; k++) b[k*ACC_W +: ACC_W] = m_res[k];
        return b;
    endfunction

    task automatic model_add(input int ch, input logic [15:0] d);
        longint s;
        bit     ov;
        res_t   e;
        s  = m_acc[ch] + longint'($signed(d));
        ov = 0;
        if (s > MAXV) begin
            s  = MAXV;
            ov = 1;
        end else if (s < MINV) begin
            s  = MINV;
            ov = 1;
        end
        if (m_cnt[ch] == BLK - 1) begin
            e.ch   = 2'(ch);
            e.data = 16'(s);
            e.sat  = m_sat[ch] | ov;
            q.push_back(e);
            m_res[ch] = 16'(s);
            m_acc[ch] = 0;
            m_cnt[ch] = 0;
            m_sat[ch] = 0;
        end else begin
            m_acc[ch] = s;
            m_cnt[ch]++;
            m_sat[ch] = m_sat[ch] | ov;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int ch, input logic [15:0] d);
        int n;
        n          = 0;
        i_in_valid = 1'b1;
        i_in_ch    = 2'(ch);
        i_in_data  = d;
        @(negedge clk);
        while (!o_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        model_add(ch, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        res_t e;
        if (n_rst && o_out_valid && i_out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_ch", o_out_ch, e.ch);
                chk("out_data", o_out_data, e.data);
                chk("out_sat", o_out_sat, e.sat);
                n_out++;
            end
        end
    end

    initial begin
        int n0;
        n_rst       = 1'b0;
        i_clr       = 1'b0;
        i_in_valid  = 1'b0;
        i_in_ch     = '0;
        i_in_data   = '0;
        i_out_ready = 1'b1;
        model_clear(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", o_out_valid, 0);
        chk("rst out_data", o_out_data, 0);
        chk("rst out_ch", o_out_ch, 0);
        chk("rst out_sat", o_out_sat, 0);
        chk("rst res_bus", o_res_bus, 0);
        n_rst = 1'b1;
        #1;
        chk("in_ready after rst", o_in_ready, 1);
        idle(1);

        // Plain block on ch2
        n0 = n_out;
        for (int i = 0; i < BLK; i++) send(2, 16'd1);
        chk("ch2 res_bus", o_res_bus, exp_bus());
        chk("ch2 res slice", o_res_bus[47:32], 16'd64);
        chk("ch2 other slices", {o_res_bus[63:48], o_res_bus[31:0]}, 0);
        idle(3);
        chk("ch2 one result", n_out - n0, 1);

        // Positive saturation on ch0
        send(0, 16'h7000);
        send(0, 16'h7000);
        chk("ch0 acc clamped", dut.r_acc[0], 16'h7FFF);
        for (int i = 0; i < BLK - 2; i++) send(0, 16'h0000);
        idle(3);

        // Negative saturation, then recovery, on ch1
        for (int i = 0; i < 3; i++) send(1, 16'h8000);
        chk("ch1 acc clamped", dut.r_acc[1], 16'h8000);
        send(1, 16'h0001);
        chk("ch1 acc recovers", dut.r_acc[1], 16'h8001);
        for (int i = 0; i < BLK - 4; i++) send(1, 16'h0000);
        idle(3);

        // Backpressure at completion on ch3
        i_out_ready = 1'b0;
        for (int i = 0; i < BLK; i++) send(3, 16'd2);
        chk("bp out_valid", o_out_valid, 1);
        chk("bp in_ready low", o_in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("bp hold data", o_out_data, 16'd128);
            chk("bp hold ch", o_out_ch, 3);
            chk("bp hold in_ready", o_in_ready, 0);
        end
        i_out_ready = 1'b1;
        idle(1);
        chk("bp valid drops", o_out_valid, 0);
        chk("bp in_ready back", o_in_ready, 1);
        idle(2);

        // Round robin, back-to-back completions
        for (int i = 0; i < BLK; i++)
            for (int k = 0; k < NCH; k++) send(k, 16'(k + 1));
        chk("rr res_bus", o_res_bus, exp_bus());
        idle(4);

        // Clear with a same-cycle sample
        for (int i = 0; i < 10; i++) send(3, 16'd1);
        i_clr      = 1'b1;
        i_in_valid = 1'b1;
        i_in_ch    = 2'd3;
        i_in_data  = 16'd5;
        @(negedge clk);
        chk("clr in_ready", o_in_ready, 0);
        @(posedge clk);
        #1;
        i_clr      = 1'b0;
        i_in_valid = 1'b0;
        model_clear(0);
        chk("clr acc3", dut.r_acc[3], 0);
        chk("clr keeps res_bus", o_res_bus, exp_bus());
        for (int i = 0; i < BLK; i++) send(3, 16'd1);
        idle(3);

        // Asynchronous reset mid-block
        for (int i = 0; i < 10; i++) send(3, 16'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid rst out_valid", o_out_valid, 0);
        chk("mid rst out_data", o_out_data, 0);
        chk("mid rst out_ch", o_out_ch, 0);
        chk("mid rst out_sat", o_out_sat, 0);
        chk("mid rst res_bus", o_res_bus, 0);
        model_clear(1);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        chk("mid rst in_ready", o_in_ready, 1);
        for (int i = 0; i < BLK; i++) send(3, 16'd1);
        chk("post rst res_bus", o_res_bus, exp_bus());
        idle(4);

        chk("queue drained", q.size(), 0);
        chk("result count", n_out, 10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
